// File: rtl/stream_gen_pkg.sv
// Shared types and constants for the framed stream generator.
package stream_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_GAP,
        ST_DONE
    } state_t;

    // Payload pattern select
    localparam logic PAT_COUNTER = 1'b0;
    localparam logic PAT_PRBS    = 1'b1;

    // Header beat field placement
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_IDX_LSB = 32;
    localparam int HDR_FIELD_W = 32;

    // x^32 + x^22 + x^2 + x + 1, Fibonacci form, shifting left:
    // feedback = s[31] ^ s[21] ^ s[1] ^ s[0], inserted at bit 0.
    localparam logic [31:0] PRBS_TAPS = 32'h8020_0003;
    localparam logic [31:0] PRBS_SEED = 32'hFFFF_FFFF;

    function automatic logic [31:0] prbs_next(input logic [31:0] s);
        return {s[30:0], ^(s & PRBS_TAPS)};
    endfunction

endpackage

// File: rtl/stream_prbs32.sv
// 32-bit LFSR payload source; load restores the seed, en advances one step.
module stream_prbs32
    import stream_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    output logic [31:0] state
);

    // Seed on reset or load, otherwise step once per enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= PRBS_SEED;
        else if (load)
            state <= PRBS_SEED;
        else if (en)
            state <= prbs_next(state);
    end

endmodule

// File: rtl/stream_frame_gen.sv
// Framed AXI-Stream traffic source: header beat + payload per frame,
// optional inter-frame gap, beat/stall statistics.
module stream_frame_gen
    import stream_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    start,
    input  logic [31:0]             cfg_frame_bytes,
    input  logic [CNT_WIDTH-1:0]    cfg_num_frames,
    input  logic [CNT_WIDTH-1:0]    cfg_gap_cycles,
    input  logic                    cfg_pattern,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    beats_sent,
    output logic [CNT_WIDTH-1:0]    stall_cycles
);

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int LANES = DATA_WIDTH / 32;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                      state;
    logic [31:0]                 bytes_q;
    logic [31:0]                 pay_beats;
    logic [31:0]                 beat_idx;
    logic [CNT_WIDTH-1:0]        nfr_q;
    logic [CNT_WIDTH-1:0]        gap_q;
    logic [CNT_WIDTH-1:0]        frame_idx;
    logic [CNT_WIDTH-1:0]        gap_cnt;
    logic                        pat_q;
    logic [31:0]                 lfsr;
    logic [31:0]                 tail;
    logic [BPB-1:0]              keep_tail;
    logic [LANES-1:0][31:0]      pay_lane;
    logic                        hs;
    logic                        start_ok;
    logic                        last_beat;

    assign hs        = m_axis_tvalid & m_axis_tready;
    assign start_ok  = start & (state == ST_IDLE);
    assign last_beat = (beat_idx == pay_beats - 32'd1);

    stream_prbs32 u_prbs (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .load  (start_ok),
        .en    (hs && (state == ST_PAY)),
        .state (lfsr)
    );

    // Per-lane payload word: counter or PRBS xor lane number
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign pay_lane[i] = (pat_q == PAT_PRBS) ? (lfsr ^ 32'(i))
                                                 : (beat_idx * 32'(LANES) + 32'(i));
    end

    // Byte enables for a short final beat; a zero remainder means a full beat
    always_comb begin
        tail = bytes_q % 32'(BPB);
        for (int j = 0; j < BPB; j++)
            keep_tail[j] = (tail == 32'd0) || (32'(j) < tail);
    end

    // Beat contents come only from flops that hold still until the handshake
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tlast = 1'b0;
        case (state)
            ST_HDR: begin
                m_axis_tdata[HDR_LEN_LSB +: HDR_FIELD_W] = bytes_q;
                m_axis_tdata[HDR_IDX_LSB +: HDR_FIELD_W] = 32'(frame_idx);
                m_axis_tkeep = '1;
            end
            ST_PAY: begin
                m_axis_tdata = pay_lane;
                m_axis_tkeep = last_beat ? keep_tail : '1;
                m_axis_tlast = last_beat;
            end
            default: ;
        endcase
    end

    // Frame sequencer with registered valid/busy/done
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state         <= ST_IDLE;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bytes_q       <= '0;
            pay_beats     <= '0;
            nfr_q         <= '0;
            gap_q         <= '0;
            pat_q         <= PAT_COUNTER;
            frame_idx     <= '0;
            beat_idx      <= '0;
            gap_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    bytes_q   <= cfg_frame_bytes;
                    pay_beats <= cfg_frame_bytes / 32'(BPB) +
                                 (((cfg_frame_bytes % 32'(BPB)) != 32'd0) ? 32'd1 : 32'd0);
                    nfr_q     <= cfg_num_frames;
                    gap_q     <= cfg_gap_cycles;
                    pat_q     <= cfg_pattern;
                    frame_idx <= '0;
                    beat_idx  <= '0;
                    if (cfg_num_frames == '0 || cfg_frame_bytes == 32'd0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state         <= ST_HDR;
                        m_axis_tvalid <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ST_HDR: if (hs) begin
                    state    <= ST_PAY;
                    beat_idx <= '0;
                end
                ST_PAY: if (hs) begin
                    beat_idx <= beat_idx + 32'd1;
                    if (last_beat) begin
                        frame_idx <= frame_idx + CNT_ONE;
                        beat_idx  <= '0;
                        if (frame_idx == nfr_q - CNT_ONE) begin
                            state         <= ST_DONE;
                            m_axis_tvalid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else if (gap_q == '0) begin
                            state <= ST_HDR;
                        end else begin
                            state         <= ST_GAP;
                            m_axis_tvalid <= 1'b0;
                            gap_cnt       <= gap_q - CNT_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state         <= ST_HDR;
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_ONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating handshake and back-pressure statistics, cleared per run
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            beats_sent   <= '0;
            stall_cycles <= '0;
        end else if (start_ok) begin
            beats_sent   <= '0;
            stall_cycles <= '0;
        end else begin
            if (hs && beats_sent != '1)
                beats_sent <= beats_sent + CNT_ONE;
            if (m_axis_tvalid && !m_axis_tready && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_stream_frame_gen.sv
// Randomized bench for stream_frame_gen against a frame-list reference model.
module tb_stream_frame_gen;

    localparam int DW    = 512;
    localparam int CW    = 8;
    localparam int BPB   = DW / 8;
    localparam int LANES = DW / 32;
    localparam int SAT   = (1 << CW) - 1;

    logic            ap_clk = 1'b0;
    logic            ap_rst = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     cfg_frame_bytes = '0;
    logic [CW-1:0]   cfg_num_frames = '0;
    logic [CW-1:0]   cfg_gap_cycles = '0;
    logic            cfg_pattern = 1'b0;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [BPB-1:0]  m_axis_tkeep;
    logic            m_axis_tlast;
    logic            busy;
    logic            done;
    logic [CW-1:0]   beats_sent;
    logic [CW-1:0]   stall_cycles;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [DW-1:0]  d;
        logic [BPB-1:0] k;
        logic           l;
    } beat_t;

    beat_t exp_q[$];

    stream_frame_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .start           (start),
        .cfg_frame_bytes (cfg_frame_bytes),
        .cfg_num_frames  (cfg_num_frames),
        .cfg_gap_cycles  (cfg_gap_cycles),
        .cfg_pattern     (cfg_pattern),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .busy            (busy),
        .done            (done),
        .beats_sent      (beats_sent),
        .stall_cycles    (stall_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference LFSR: x^32+x^22+x^2+x+1, new bit enters at the bottom
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic logic pick(input int mode, input int cyc);
        case (mode)
            2:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            3:       return 1'($urandom % 2);
            4:       return ($urandom % 4) == 0;
            default: return 1'b1;
        endcase
    endfunction

    // Expected beat list for a whole run, straight from the frame rules
    task automatic build(input int unsigned fb, input int unsigned nf, input bit pat);
        logic [31:0]    lf;
        logic [BPB-1:0] ones;
        int             nb;
        int             rem;
        beat_t          b;
        exp_q.delete();
        lf   = 32'hFFFF_FFFF;
        ones = '1;
        nb   = int'((fb + BPB - 1) / BPB);
        rem  = int'(fb % BPB);
        if (fb == 0 || nf == 0) return;
        for (int f = 0; f < int'(nf); f++) begin
            b.d = '0;
            b.d[31:0]  = fb;
            b.d[63:32] = 32'(f);
            b.k = '1;
            b.l = 1'b0;
            exp_q.push_back(b);
            for (int k = 0; k < nb; k++) begin
                for (int i = 0; i < LANES; i++)
                    b.d[i*32 +: 32] = pat ? (lf ^ 32'(i)) : 32'(k * LANES + i);
                if (pat) lf = lfsr_step(lf);
                b.k = (k == nb - 1 && rem != 0) ? (ones >> (BPB - rem)) : ones;
                b.l = (k == nb - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic run(input int unsigned fb, input int unsigned nf, input int unsigned gap,
                       input bit pat, input int mode, input int abort_at);
        int    cyc = 0, stalls = 0, frames = 0, gap_cnt = 0, total;
        bit    gap_on = 0, done_next = 0, held_v = 0, fin = 0, seen = 0;
        beat_t held, cur, e;
        build(fb, nf, pat);
        total = exp_q.size();
        @(negedge ap_clk);
        cfg_frame_bytes = fb;
        cfg_num_frames  = CW'(nf);
        cfg_gap_cycles  = CW'(gap);
        cfg_pattern     = pat;
        start           = 1'b1;
        m_axis_tready   = 1'b1;
        if (total == 0) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge ap_clk);
                start = 1'b0;
                chk("zero_tvalid", m_axis_tvalid, 0);
                if (done) begin
                    seen = 1;
                    chk("zero_beats_sent", beats_sent, 0);
                end
            end
            chk("zero_done", seen, 1);
            return;
        end
        while (!fin && cyc < 20000) begin
            @(negedge ap_clk);
            start = 1'b0;
            if (cyc == 0) begin
                cfg_frame_bytes = $urandom;
                cfg_num_frames  = CW'($urandom);
                cfg_gap_cycles  = CW'($urandom);
                cfg_pattern     = 1'($urandom);
                chk("tvalid_rise", m_axis_tvalid, 1);
            end
            if (cyc == abort_at) return;
            m_axis_tready = pick(mode, cyc);
            cur.d = m_axis_tdata;
            cur.k = m_axis_tkeep;
            cur.l = m_axis_tlast;
            chk("done", done, done_next);
            if (done_next) begin
                chk("busy_at_done", busy, 0);
                chk("beats_sent", beats_sent, sat(total));
                chk("stall_cycles", stall_cycles, sat(stalls));
                chk("leftover", exp_q.size(), 0);
                fin = 1;
            end else begin
                chk("busy_run", busy, 1);
                if (held_v) begin
                    chk("stable_v", m_axis_tvalid, 1);
                    chk("stable_d", cur.d, held.d);
                    chk("stable_k", cur.k, held.k);
                    chk("stable_l", cur.l, held.l);
                end
                if (gap_on && m_axis_tvalid) begin
                    chk("gap_len", gap_cnt, gap);
                    gap_on = 0;
                end else if (gap_on) begin
                    gap_cnt++;
                end
                held_v = m_axis_tvalid && !m_axis_tready;
                held   = cur;
                if (held_v) stalls++;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1, 0);
                        fin = 1;
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", cur.d, e.d);
                        chk("tkeep", cur.k, e.k);
                        chk("tlast", cur.l, e.l);
                        if (e.l) begin
                            frames++;
                            if (frames == int'(nf)) done_next = 1;
                            else begin gap_on = 1; gap_cnt = 0; end
                        end
                    end
                end
                // a start while busy must be ignored
                if (cyc == 2) start = 1'b1;
            end
            cyc++;
        end
        start = 1'b0;
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge ap_clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_beats", beats_sent, 0);
        chk("rst_stalls", stall_cycles, 0);
        ap_rst = 1'b0;

        run(128, 1, 0, 0, 1, -1);
        run(100, 2, 4, 0, 1, -1);
        run(256, 1, 0, 0, 2, -1);
        run(64, 2, 0, 1, 1, -1);
        run(64, 0, 3, 0, 1, -1);
        run(0, 2, 0, 1, 1, -1);
        for (int r = 0; r < 8; r++)
            run($urandom_range(1, 300), $urandom_range(1, 3), $urandom_range(0, 5),
                1'($urandom), 3, -1);

        // reset in the middle of a payload, then a fresh run
        run(512, 1, 0, 0, 1, 5);
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_tdata", m_axis_tdata, 0);
        chk("mid_rst_tkeep", m_axis_tkeep, 0);
        chk("mid_rst_tlast", m_axis_tlast, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_beats", beats_sent, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run(100, 2, 1, 1, 3, -1);

        // counter saturation
        run(64 * 300, 1, 0, 0, 1, -1);
        run(64 * 150, 1, 0, 0, 4, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_frame_gen.md
# stream_frame_gen

Upstream traffic source for the streaming throughput kernel. It generates framed AXI-Stream traffic on the 512-bit external data path and drives the kernel's `s_axis_in` port. Each frame is one 64-bit-header beat followed by a parameterizable payload, so the downstream stage can split the traffic into config and sample streams. The block keeps beat and stall counters so host software can measure sustained throughput and back-pressure.

## Interface
Parameters:
- `DATA_WIDTH`, 512: stream data width in bits; must be a multiple of 32, ≥ 64.
- `CNT_WIDTH`, 32: width of the frame-count, gap and statistics counters.

Ports:
- `ap_clk`  in  1  sole clock.
- `ap_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; latches config and begins a run. Only accepted in IDLE.
- `cfg_frame_bytes`  in  32  payload bytes per frame.
- `cfg_num_frames`  in  CNT_WIDTH  frames per run.
- `cfg_gap_cycles`  in  CNT_WIDTH  idle cycles between frames.
- `cfg_pattern`  in  1  payload pattern: 0 = counter, 1 = PRBS.
- `m_axis_tdata`  out  DATA_WIDTH  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tkeep`  out  DATA_WIDTH/8  byte enables.
- `m_axis_tlast`  out  1  last beat of a frame.
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  one-cycle pulse at end of run.
- `beats_sent`  out  CNT_WIDTH  handshakes in the current or last run.
- `stall_cycles`  out  CNT_WIDTH  cycles with tvalid high and tready low.

## Operation
- FSM states and transitions:
  - IDLE to HDR when `start` is seen.
  - HDR to PAY on the header handshake.
  - PAY to GAP, HDR or DONE on the tlast handshake.
  - GAP to HDR when the gap counter expires.
  - DONE to IDLE after one cycle.
- On `start`, all `cfg_*` inputs are latched, and `beats_sent` and `stall_cycles` are cleared.
- If `cfg_num_frames`==0 or `cfg_frame_bytes`==0, the FSM goes straight to DONE and no beats are sent.
- Header beat:
  - tdata[31:0] = frame_bytes; tdata[63:32] = frame index, starting at 0.
  - All other tdata bits are 0; tkeep is all ones; tlast = 0.
- Payload:
  - Beat count = ceil(frame_bytes / (DATA_WIDTH/8)).
  - tlast is asserted only on the final payload beat.
  - tkeep is all ones, except on the last beat when frame_bytes mod (DATA_WIDTH/8) ≠ 0. That beat sets the low (frame_bytes mod (DATA_WIDTH/8)) bits.
- Counter pattern: 32-bit lane i of payload beat b = b·(DATA_WIDTH/32)+i. The beat index b restarts at 0 every frame.
- PRBS pattern:
  - A 32-bit LFSR with polynomial x^32+x^22+x^2+x+1 and seed 0xFFFFFFFF is loaded on `start`.
  - The LFSR advances once per payload handshake and continues across frames.
  - Lane i = lfsr XOR i.
- After a non-final frame, the FSM waits `cfg_gap_cycles` cycles in GAP, then moves to HDR. No gap is inserted after the final frame.
- `start` while busy is ignored. Config changes while busy have no effect.

## Timing
- Reset values: all outputs are 0 (tvalid, tlast, tkeep, tdata, busy, done, both counters). The FSM is in IDLE and the LFSR is at its seed.
- Reset mid-run: all outputs clear immediately and the frame is truncated.
- tvalid rises the cycle after the `start` pulse.
- AXIS rules:
  - Once tvalid is asserted, tdata, tkeep and tlast stay stable until the handshake.
  - tvalid never drops without a handshake.
- With gap 0, the next header is valid in the cycle after the tlast handshake. Throughput is 1 beat/cycle when tready is tied high.
- With gap G, tvalid is low for exactly G cycles between the tlast handshake and the next header.
- `done` pulses the cycle after the final tlast handshake. `busy` falls in the same cycle.
- Counters update on the clock edge following the qualifying cycle. They saturate at all ones.

## Structure
- Package `stream_gen_pkg` holds:
  - the state enum;
  - pattern codes;
  - header field offsets (length [31:0], index [63:32]);
  - the LFSR polynomial and seed.
- Sub-module `stream_prbs32` implements the 32-bit LFSR with load and enable inputs.

## Test plan
- frame_bytes=128, num_frames=1, counter pattern, tready=1:
  - 3 beats: header, then two payload beats with lane 0 = 0 and 16.
  - tlast on beat 3; done 1 cycle later; beats_sent = 3.
- frame_bytes=100, num_frames=2, gap=4:
  - Each frame is 1+2 beats; last-beat tkeep = 0x0000000FFFFFFFFF (36 bytes).
  - Header indices are 0 and 1; tvalid is low for exactly 4 cycles between frames.
- tready toggling 1,0,0,1 during frame_bytes=256:
  - Data stays stable during stalls; no beat is lost or duplicated.
  - stall_cycles equals the number of low-ready cycles while valid.
- PRBS pattern, 2 frames of 64 bytes:
  - Lane 0 of the first payload beat = 0xFFFFFFFF; the second frame continues the sequence (next LFSR state).
- num_frames=0: done pulses within 2 cycles of start; tvalid never rises.
- Reset asserted mid-payload, then a new start:
  - Outputs are 0 during reset.
  - The new run begins with header index 0 and beats_sent restarts from 0.
